// File: rtl/mem_arbiter.sv
// mem_arbiter: sequencer/arbiter for the stage-three main data memory.
// Shares the single mem_main port between the pipeline load/store path and the
// debug/loader port, holds each access for WAIT_STATES extra cycles and drives
// the pipeline stall while a pipeline access is outstanding.
// Optional feature macro: MEM_ARB_STARVE_EN (debug anti-starvation override).
module mem_arbiter #(
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_sys,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [15:0] p_addr,
    input  logic [15:0] p_wdata,
    output logic [15:0] p_rdata,
    output logic        p_done,
    output logic        p_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_we,
    input  logic [15:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_P = 2'd1,
        ACC_D = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        last_cycle;
    logic        arb_open;
    logic        starve_ovr;
    logic        grant_p;
    logic        grant_d;

    // Arbitration only happens in IDLE and never in a done cycle, so a finished
    // requester cannot be re-granted back to back and each access costs WAIT_STATES+3.
    assign arb_open = (state == IDLE) & ~p_done & ~d_done;

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    assign starve_ovr = d_req & (starve_cnt == STARVE_MAX);

    // Count pipeline grants made while debug waits; any debug grant or idle debug port clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!d_req || grant_d) begin
                starve_cnt <= 4'd0;
            end else if (grant_p) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign starve_ovr = 1'b0;
`endif

    assign grant_p = arb_open & p_req & ~halt_sys & ~starve_ovr;
    assign grant_d = arb_open & d_req & ~grant_p;

    assign last_cycle = (state != IDLE) && (wait_cnt == 3'd0);
    assign m_we       = last_cycle & req_we;
    assign m_addr     = req_addr;
    assign m_wdata    = req_wdata;
    assign p_stall    = p_req & ~p_done;

    // Access sequencer: latch the winner, count down wait states, capture read data and pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            req_we    <= 1'b0;
            req_addr  <= 16'd0;
            req_wdata <= 16'd0;
            p_done    <= 1'b0;
            d_done    <= 1'b0;
            p_rdata   <= 16'd0;
            d_rdata   <= 16'd0;
        end else begin
            p_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_p) begin
                        state     <= ACC_P;
                        req_we    <= p_we;
                        req_addr  <= p_addr;
                        req_wdata <= p_wdata;
                        wait_cnt  <= WAIT_LOAD;
                    end else if (grant_d) begin
                        state     <= ACC_D;
                        req_we    <= d_we;
                        req_addr  <= d_addr;
                        req_wdata <= d_wdata;
                        wait_cnt  <= WAIT_LOAD;
                    end
                end
                ACC_P, ACC_D: begin
                    if (wait_cnt == 3'd0) begin
                        state <= IDLE;
                        if (state == ACC_P) begin
                            p_done <= 1'b1;
                            if (!req_we) begin
                                p_rdata <= m_rdata;
                            end
                        end else begin
                            d_done <= 1'b1;
                            if (!req_we) begin
                                d_rdata <= m_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Three instances (WAIT_STATES 0, 3, 2) share one clock; each has its own reset
// and a 256-word memory model. Stimulus pushes expected done events into a queue,
// a negedge monitor pops and compares them whenever a done pulse appears.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int N_INST = 3;

`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    typedef struct {
        int          inst;
        bit          port_d;
        int          done_cyc;
        bit          is_read;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [N_INST];
    logic        halt_sys [N_INST];
    logic        p_req    [N_INST];
    logic        p_we     [N_INST];
    logic [15:0] p_addr   [N_INST];
    logic [15:0] p_wdata  [N_INST];
    logic [15:0] p_rdata  [N_INST];
    logic        p_done   [N_INST];
    logic        p_stall  [N_INST];
    logic        d_req    [N_INST];
    logic        d_we     [N_INST];
    logic [15:0] d_addr   [N_INST];
    logic [15:0] d_wdata  [N_INST];
    logic [15:0] d_rdata  [N_INST];
    logic        d_done   [N_INST];
    logic [15:0] m_addr   [N_INST];
    logic [15:0] m_wdata  [N_INST];
    logic        m_we     [N_INST];
    logic [15:0] m_rdata  [N_INST];
    logic [15:0] mem      [N_INST][256];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   we_cnt    [N_INST];
    int   stall_cnt [N_INST];
    exp_t exp_q [$];

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        mem_arbiter #(
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2),
            .STARVE_LIMIT(4)
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .halt_sys(halt_sys[g]),
            .p_req   (p_req[g]),
            .p_we    (p_we[g]),
            .p_addr  (p_addr[g]),
            .p_wdata (p_wdata[g]),
            .p_rdata (p_rdata[g]),
            .p_done  (p_done[g]),
            .p_stall (p_stall[g]),
            .d_req   (d_req[g]),
            .d_we    (d_we[g]),
            .d_addr  (d_addr[g]),
            .d_wdata (d_wdata[g]),
            .d_rdata (d_rdata[g]),
            .d_done  (d_done[g]),
            .m_addr  (m_addr[g]),
            .m_wdata (m_wdata[g]),
            .m_we    (m_we[g]),
            .m_rdata (m_rdata[g])
        );
    end

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Cycle number: cycle c is the interval after the c-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the rising edge when m_we is high.
    always_comb begin
        for (int i = 0; i < N_INST; i++) begin
            m_rdata[i] = mem[i][m_addr[i][7:0]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            if (m_we[i] === 1'b1) mem[i][m_addr[i][7:0]] <= m_wdata[i];
        end
    end

    function automatic void check_output(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void score(int inst, bit port_d, logic [15:0] rdata);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("[TB] FAIL unexpected_done: inst%0d port %s pulsed with nothing expected (cycle %0d)",
                     inst, port_d ? "d" : "p", cyc);
            return;
        end
        e = exp_q.pop_front();
        check_output($sformatf("done_inst@%0d", cyc), inst, e.inst);
        check_output($sformatf("done_port@%0d", cyc), 32'(port_d), 32'(e.port_d));
        check_output($sformatf("done_cycle_i%0d", inst), cyc, e.done_cyc);
        if (e.is_read) check_output($sformatf("rdata_i%0d_%s", inst, port_d ? "d" : "p"), rdata, e.rdata);
    endfunction

    // Scoreboard monitor: compare every done pulse against the queue, tally m_we and p_stall cycles.
    always @(negedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            if (m_we[i] === 1'b1) we_cnt[i]++;
            if (p_stall[i] === 1'b1) stall_cnt[i]++;
            if (p_done[i] === 1'b1) score(i, 1'b0, p_rdata[i]);
            if (d_done[i] === 1'b1) score(i, 1'b1, d_rdata[i]);
        end
    end

    task automatic expect_done(int inst, bit port_d, int done_cyc, bit is_read, logic [15:0] rdata);
        exp_t e;
        e.inst     = inst;
        e.port_d   = port_d;
        e.done_cyc = done_cyc;
        e.is_read  = is_read;
        e.rdata    = rdata;
        exp_q.push_back(e);
    endtask

    task automatic run_to(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(int inst, bit port_d, bit req, bit we, logic [15:0] addr, logic [15:0] wdata);
        if (port_d) begin
            d_req[inst]   = req;
            d_we[inst]    = we;
            d_addr[inst]  = addr;
            d_wdata[inst] = wdata;
        end else begin
            p_req[inst]   = req;
            p_we[inst]    = we;
            p_addr[inst]  = addr;
            p_wdata[inst] = wdata;
        end
    endtask

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int k;
        int k2;
        int we0;
        int s0;
        bit pd;

        for (int i = 0; i < N_INST; i++) begin
            rst[i]       = 1'b1;
            halt_sys[i]  = 1'b0;
            we_cnt[i]    = 0;
            stall_cnt[i] = 0;
            apply_stimulus(i, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            apply_stimulus(i, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            for (int a = 0; a < 256; a++) mem[i][a] = 16'hC000 | 16'(a);
            mem[i][8'h20] = 16'h1234;
        end
        #1;
        for (int i = 0; i < N_INST; i++) rst[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N_INST; i++) begin
            check_output($sformatf("reset_p_rdata_i%0d", i), p_rdata[i], 0);
            check_output($sformatf("reset_d_rdata_i%0d", i), d_rdata[i], 0);
            check_output($sformatf("reset_m_addr_i%0d", i), m_addr[i], 0);
            check_output($sformatf("reset_m_wdata_i%0d", i), m_wdata[i], 0);
            check_output($sformatf("reset_m_we_i%0d", i), m_we[i], 0);
            check_output($sformatf("reset_p_done_i%0d", i), p_done[i], 0);
            check_output($sformatf("reset_d_done_i%0d", i), d_done[i], 0);
        end
        for (int i = 0; i < N_INST; i++) rst[i] = 1'b1;
        @(posedge clk);
        #1;

        // Pipeline write then read, WAIT_STATES=0
        k   = cyc;
        we0 = we_cnt[0];
        s0  = stall_cnt[0];
        apply_stimulus(0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        expect_done(0, 1'b0, k + 2, 1'b0, 16'h0);
        run_to(k + 1);
        check_output("t1_write_m_we", m_we[0], 1);
        check_output("t1_write_m_addr", m_addr[0], 16'h0010);
        check_output("t1_write_m_wdata", m_wdata[0], 16'hBEEF);
        check_output("t1_write_p_stall", p_stall[0], 1);
        run_to(k + 2);
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
        run_to(k + 3);
        apply_stimulus(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        expect_done(0, 1'b0, k + 5, 1'b1, 16'hBEEF);
        run_to(k + 4);
        check_output("t1_read_m_we", m_we[0], 0);
        check_output("t1_read_m_addr", m_addr[0], 16'h0010);
        run_to(k + 5);
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_to(k + 6);
        check_output("t1_we_pulses", we_cnt[0] - we0, 1);
        check_output("t1_stall_cycles", stall_cnt[0] - s0, 4);

        // Debug read with WAIT_STATES=3
        k = cyc;
        check_output("t2_m_addr_before", m_addr[1], 0);
        apply_stimulus(1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        expect_done(1, 1'b1, k + 5, 1'b1, 16'h1234);
        for (int j = 1; j <= 4; j++) begin
            run_to(k + j);
            check_output($sformatf("t2_m_addr_c%0d", j), m_addr[1], 16'h0020);
            check_output($sformatf("t2_m_we_c%0d", j), m_we[1], 0);
        end
        run_to(k + 5);
        apply_stimulus(1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        // Halt rising during a pipeline access does not abort it
        run_to(k + 6);
        k2 = cyc;
        apply_stimulus(1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        expect_done(1, 1'b0, k2 + 5, 1'b1, 16'h1234);
        run_to(k2 + 2);
        halt_sys[1] = 1'b1;
        run_to(k2 + 3);
        check_output("t2_halt_p_stall", p_stall[1], 1);
        run_to(k2 + 5);
        apply_stimulus(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        halt_sys[1] = 1'b0;
        run_to(k2 + 6);

        // Contention: pipeline first, then debug
        k = cyc;
        apply_stimulus(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        apply_stimulus(0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        expect_done(0, 1'b0, k + 2, 1'b1, 16'hBEEF);
        expect_done(0, 1'b1, k + 5, 1'b1, 16'h1234);
        run_to(k + 2);
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_to(k + 5);
        apply_stimulus(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        run_to(k + 6);

        // Contention with halt: only debug is served, pipeline stays stalled
        k   = cyc;
        we0 = we_cnt[0];
        halt_sys[0] = 1'b1;
        apply_stimulus(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        apply_stimulus(0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h5555);
        expect_done(0, 1'b1, k + 2, 1'b0, 16'h0);
        run_to(k + 2);
        apply_stimulus(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int j = 2; j <= 5; j++) begin
            run_to(k + j);
            check_output($sformatf("t3_halt_p_stall_c%0d", j), p_stall[0], 1);
        end
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        halt_sys[0] = 1'b0;
        run_to(k + 6);
        check_output("t3_halt_we_pulses", we_cnt[0] - we0, 1);
        k = cyc;
        apply_stimulus(0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0);
        expect_done(0, 1'b1, k + 2, 1'b1, 16'h5555);
        run_to(k + 2);
        apply_stimulus(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        run_to(k + 3);

        // Starvation: pipeline held, debug waiting; every 5th slot is debug only with the override
        k = cyc;
        apply_stimulus(0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
        apply_stimulus(0, 1'b1, 1'b1, 1'b0, 16'h0031, 16'h0);
        for (int j = 0; j < 10; j++) begin
            pd = STARVE_EN && ((j % 5) == 4);
            expect_done(0, pd, k + 2 + 3 * j, 1'b1, pd ? 16'hC031 : 16'hC030);
        end
        expect_done(0, 1'b1, k + 32, 1'b1, 16'hC031);
        run_to(k + 29);
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_to(k + 32);
        apply_stimulus(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        run_to(k + 33);

        // Reset in the commit cycle of a debug write, WAIT_STATES=2
        k   = cyc;
        we0 = we_cnt[2];
        apply_stimulus(2, 1'b1, 1'b1, 1'b1, 16'h0050, 16'hDEAD);
        run_to(k + 3);
        check_output("t5_m_we_before_reset", m_we[2], 1);
        check_output("t5_m_addr_before_reset", m_addr[2], 16'h0050);
        rst[2] = 1'b0;
        apply_stimulus(2, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        check_output("t5_m_we_after_reset", m_we[2], 0);
        check_output("t5_m_addr_after_reset", m_addr[2], 0);
        check_output("t5_d_done_after_reset", d_done[2], 0);
        run_to(k + 5);
        rst[2] = 1'b1;
        run_to(k + 6);
        k2 = cyc;
        apply_stimulus(2, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h0);
        expect_done(2, 1'b1, k2 + 4, 1'b1, 16'hC050);
        run_to(k2 + 4);
        apply_stimulus(2, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        run_to(k2 + 6);
        check_output("t5_we_pulses", we_cnt[2] - we0, 0);

        check_output("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the main data memory in stage three. It shares the single `mem_main` port between the pipeline's load/store path and a secondary debug/loader port, inserts a configurable number of wait states per access, and drives the pipeline stall while a pipeline access is pending. It sits between stage-three datapath logic and `mem_main`, and owns every `mem_main` address, write-data and write-enable signal.

## Interface
- `WAIT_STATES`, default 0: extra cycles each access holds the memory bus (0–7).
- `STARVE_LIMIT`, default 4: consecutive pipeline grants allowed while `d_req` waits (only used with `MEM_ARB_STARVE_EN`; range 1–15).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `halt_sys`  in  1  while high, pipeline requests are not arbitrated.
- `p_req`  in  1  pipeline access request; held until `p_done`.
- `p_we`  in  1  pipeline write (1) / read (0).
- `p_addr`  in  16  pipeline address (ALU result).
- `p_wdata`  in  16  pipeline store data (r1 data).
- `p_rdata`  out  16  last pipeline read data, registered.
- `p_done`  out  1  one-cycle completion pulse for the pipeline port.
- `p_stall`  out  1  combinational `p_req & ~p_done`.
- `d_req`, `d_we`, `d_addr[15:0]`, `d_wdata[15:0]`  in  debug port request, same rules as the pipeline port.
- `d_rdata`  out  16  last debug read data, registered.
- `d_done`  out  1  one-cycle completion pulse for the debug port.
- `m_addr`  out  16  to `mem_main` address.
- `m_wdata`  out  16  to `mem_main` write_data.
- `m_we`  out  1  to `mem_main` write_en.
- `m_rdata`  in  16  from `mem_main` data_out, combinational read.

## Operation
- FSM states: `IDLE`, `ACC_P`, `ACC_D`.
- In `IDLE`, arbitration is evaluated each cycle:
  - Pipeline wins when `p_req & ~halt_sys` and no starvation override is active.
  - Otherwise debug wins if `d_req`.
  - The winner's `we`, `addr` and `wdata` are latched into request registers, the wait counter is loaded with `WAIT_STATES`, and the FSM moves to `ACC_P` or `ACC_D`.
- In `ACC_x`:
  - `m_addr` and `m_wdata` come from the latched registers.
  - The counter decrements each cycle. The last cycle is the one where the counter equals 0.
  - On the last cycle:
    - `m_we` equals the latched `we`. `m_we` is 0 on every other cycle, so each write commits exactly once.
    - If it is a read, `m_rdata` is captured into `x_rdata` at the clock edge.
    - `x_done` pulses on the following cycle, and the FSM returns to `IDLE`.
  - Writes leave `x_rdata` unchanged.
- `x_done` is registered and high for exactly one cycle, during which the FSM is in `IDLE`.
- A requester still asserting `x_req` during its own `x_done` cycle is not re-granted in that cycle. It competes again from the next cycle.
- In `IDLE`, `m_addr` and `m_wdata` hold their last values and `m_we` is 0.
- Request inputs are sampled only in `IDLE`. Changes during `ACC_x` are ignored.
- `halt_sys` rising during `ACC_P` does not abort the access, which completes normally.

## Timing
- Latency, from the request seen in `IDLE` to `x_done`: `WAIT_STATES + 2` cycles, when there is no contention.
- Throughput: one access per `WAIT_STATES + 3` cycles, including the done/`IDLE` cycle.
- Reset values:
  - State `IDLE`.
  - `p_done`, `d_done` and `m_we` are 0.
  - `p_rdata`, `d_rdata`, `m_addr` and `m_wdata` are 0.
  - The starvation counter is 0.
- Reset asserted mid-access: the FSM goes to `IDLE` immediately, `m_we` drops asynchronously, and no done pulse is issued. The requester must re-request after reset.
- Simultaneous `p_req` and `d_req`: the pipeline wins unless the port is halted or the starvation override is active.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - A 4-bit counter increments on each pipeline grant made while `d_req` is high.
  - It clears on any debug grant and whenever `d_req` is low in `IDLE`.
  - When the counter equals `STARVE_LIMIT`, the next arbitration with `d_req` high grants debug regardless of `p_req`.
- `MEM_ARB_STARVE_EN` undefined: strict pipeline priority. The counter is not instantiated, and debug is served only when the pipeline is idle or halted.

## Test plan
- **Pipeline write then read:** with `WAIT_STATES=0`, write `p_addr=0x0010`, `p_wdata=0xBEEF`, then read `0x0010`. Required: one `m_we` pulse per write; `p_done` 2 cycles after each request; `p_rdata=0xBEEF`; `p_stall` high for exactly 2 cycles per access.
- **Wait states:** with `WAIT_STATES=3`, a debug read of `0x0020` returns `0x1234` from memory. Required: `m_addr=0x0020` held 4 cycles; `d_done` at cycle 5; `d_rdata=0x1234`.
- **Contention with halt:** `p_req` and `d_req` both rise in the same cycle. Required: pipeline served first, then debug. Repeat with `halt_sys=1`: only debug is served, and `p_stall` stays high.
- **Starvation override:** with `MEM_ARB_STARVE_EN`, `STARVE_LIMIT=4`, `p_req` held continuously and `d_req` high. Required: grants alternate as 4 pipeline accesses, then 1 debug access. Without the macro: debug is never served.
- **Reset mid-write:** assert `rst=0` during `ACC_D` of a write with `WAIT_STATES=2`. Required: `m_we` is 0 immediately, the FSM is in `IDLE`, there is no `d_done`, and memory is unchanged.
